// File: rtl/enemy_bullet_gen.sv
// Enemy projectile generator: spawns a bullet under an active enemy on a frame-tick
// cooldown, moves it down each frame and retires it on a hit or when it leaves the screen.
module enemy_bullet_gen #(
    parameter int unsigned SCREEN_H      = 480,
    parameter int unsigned SCREEN_W      = 640,
    parameter int unsigned STEP          = 4,
    parameter int unsigned FIRE_INTERVAL = 60,
    parameter int unsigned X_OFF         = 20,
    parameter int unsigned ENEMY_H       = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       enemy_en,
    input  logic [9:0] e_x,
    input  logic [9:0] e_y,
    input  logic       hit,
    output logic [9:0] eb_x,
    output logic [9:0] eb_y,
    output logic       enemy_bullet_en,
    output logic       fire,
    output logic [7:0] shots
);

    localparam int unsigned PW = 10;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned CW = $clog2(FIRE_INTERVAL) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        FLIGHT   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [SW-1:0] spawn_x_sum;
    logic [SW-1:0] spawn_y_sum;
    logic [SW-1:0] next_y;
    logic [PW-1:0] spawn_x;
    logic          spawn_on_screen;
    logic          cnt_last;
    logic          off_screen;

    // Sums are one bit wider so a wrap past 1023 cannot alias back on screen.
    assign spawn_x_sum     = SW'(e_x) + SW'(X_OFF);
    assign spawn_y_sum     = SW'(e_y) + SW'(ENEMY_H);
    assign next_y          = SW'(eb_y) + SW'(STEP);
    assign spawn_x         = (spawn_x_sum > SW'(SCREEN_W - 1)) ? PW'(SCREEN_W - 1)
                                                               : spawn_x_sum[PW-1:0];
    assign spawn_on_screen = (spawn_y_sum < SW'(SCREEN_H));
    assign cnt_last        = (cnt == CW'(FIRE_INTERVAL - 1));
    assign off_screen      = (next_y >= SW'(SCREEN_H));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            eb_x            <= '0;
            eb_y            <= '0;
            enemy_bullet_en <= 1'b0;
            fire            <= 1'b0;
            shots           <= '0;
        end else begin
            fire <= 1'b0;
            case (state)
                IDLE: begin
                    enemy_bullet_en <= 1'b0;
                    if (enemy_en) begin
                        state <= COOLDOWN;
                        cnt   <= '0;
                    end
                end

                COOLDOWN: begin
                    if (!enemy_en) begin
                        state <= IDLE;
                    end else if (frame_tick) begin
                        if (cnt_last) begin
                            // A spawn below the playfield still counts as a shot.
                            fire  <= 1'b1;
                            shots <= shots + 8'd1;
                            cnt   <= '0;
                            if (spawn_on_screen) begin
                                eb_x            <= spawn_x;
                                eb_y            <= spawn_y_sum[PW-1:0];
                                enemy_bullet_en <= 1'b1;
                                state           <= FLIGHT;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                FLIGHT: begin
                    // Hit outranks movement; either retirement restarts the cooldown.
                    if (hit || (frame_tick && off_screen)) begin
                        enemy_bullet_en <= 1'b0;
                        cnt             <= '0;
                        state           <= enemy_en ? COOLDOWN : IDLE;
                    end else if (frame_tick) begin
                        eb_y <= next_y[PW-1:0];
                    end
                end

                default: begin
                    state           <= IDLE;
                    cnt             <= '0;
                    enemy_bullet_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_bullet_gen.sv
// Scoreboard bench for enemy_bullet_gen: directed stimulus queues expected output
// snapshots, a monitor pops one whenever the DUT outputs change.
module tb_enemy_bullet_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
        logic       fire;
        logic [7:0] shots;
    } snap_t;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       enemy_en;
    logic [9:0] e_x;
    logic [9:0] e_y;
    logic       hit;
    logic [9:0] eb_x;
    logic [9:0] eb_y;
    logic       enemy_bullet_en;
    logic       fire;
    logic [7:0] shots;

    int total = 0;
    int bad   = 0;

    snap_t expq[$];
    string nameq[$];
    snap_t es;

    enemy_bullet_gen dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .enemy_en        (enemy_en),
        .e_x             (e_x),
        .e_y             (e_y),
        .hit             (hit),
        .eb_x            (eb_x),
        .eb_y            (eb_y),
        .enemy_bullet_en (enemy_bullet_en),
        .fire            (fire),
        .shots           (shots)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic snap_t cur_snap();
        snap_t s;
        s.x     = eb_x;
        s.y     = eb_y;
        s.en    = enemy_bullet_en;
        s.fire  = fire;
        s.shots = shots;
        return s;
    endfunction

    // Monitor: every change of the output bundle must match the next queued snapshot.
    initial begin : monitor
        snap_t prev;
        snap_t cur;
        snap_t e;
        string nm;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = cur_snap();
            if (cur !== prev) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got x=%0d y=%0d en=%0b fire=%0b shots=%0d, required no change",
                             cur.x, cur.y, cur.en, cur.fire, cur.shots);
                end else begin
                    e  = expq.pop_front();
                    nm = nameq.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL %s: got x=%0d y=%0d en=%0b fire=%0b shots=%0d, required x=%0d y=%0d en=%0b fire=%0b shots=%0d",
                                 nm, cur.x, cur.y, cur.en, cur.fire, cur.shots,
                                 e.x, e.y, e.en, e.fire, e.shots);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic push(input string nm);
        expq.push_back(es);
        nameq.push_back(nm);
    endtask

    task automatic check_now(input string nm, input snap_t req);
        snap_t got;
        got = cur_snap();
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d en=%0b fire=%0b shots=%0d, required x=%0d y=%0d en=%0b fire=%0b shots=%0d",
                     nm, got.x, got.y, got.en, got.fire, got.shots,
                     req.x, req.y, req.en, req.fire, req.shots);
        end
    endtask

    task automatic tick_none();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic tick_spawn(input logic [9:0] x, input logic [9:0] y, input logic live);
        @(negedge clk);
        frame_tick = 1'b1;
        es.fire  = 1'b1;
        es.shots = es.shots + 8'd1;
        if (live) begin
            es.x  = x;
            es.y  = y;
            es.en = 1'b1;
        end
        push(live ? "spawn" : "spawn_offscreen");
        es.fire = 1'b0;
        push("fire_low");
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic cooldown_spawn(input logic [9:0] x, input logic [9:0] y, input logic live);
        repeat (59) tick_none();
        tick_spawn(x, y, live);
    endtask

    task automatic tick_move();
        @(negedge clk);
        frame_tick = 1'b1;
        es.y = es.y + 10'd4;
        push("move");
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic fly_out();
        while (int'(es.y) + 4 < 480) tick_move();
        @(negedge clk);
        frame_tick = 1'b1;
        es.en = 1'b0;
        push("retire_offscreen");
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic hit_pulse(input logic with_tick, input logic live);
        @(negedge clk);
        hit        = 1'b1;
        frame_tick = with_tick;
        if (live) begin
            es.en = 1'b0;
            push("retire_hit");
        end
        @(negedge clk);
        hit        = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin : stimulus
        snap_t zero;
        zero       = '0;
        es         = '0;
        rst        = 1'b0;
        frame_tick = 1'b0;
        enemy_en   = 1'b0;
        e_x        = 10'd100;
        e_y        = 10'd50;
        hit        = 1'b0;
        #3 rst = 1'b1;
        #4 check_now("reset_state", zero);
        @(negedge clk);
        rst = 1'b0;

        // Idle with enemy dead: ticks and hits must do nothing.
        repeat (3) tick_none();
        hit_pulse(1'b0, 1'b0);

        // Enable with a coincident tick that must not be counted.
        @(negedge clk);
        enemy_en   = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cooldown_spawn(10'd120, 10'd90, 1'b1);

        // Full flight to the bottom, then exactly 60 ticks to the next spawn.
        fly_out();
        e_y = 10'd52;
        cooldown_spawn(10'd120, 10'd92, 1'b1);

        // Reach y=200 and hit on a tick: no move, single retirement.
        repeat (27) tick_move();
        hit_pulse(1'b1, 1'b1);
        repeat (3) tick_none();
        hit_pulse(1'b0, 1'b0);

        // X saturation, then a plain hit.
        e_x = 10'd630;
        e_y = 10'd100;
        repeat (56) tick_none();
        tick_spawn(10'd639, 10'd140, 1'b1);
        tick_move();
        hit_pulse(1'b0, 1'b1);

        // Spawn below the playfield: shot counted, no bullet, cooldown restarts.
        e_y = 10'd450;
        cooldown_spawn(10'd0, 10'd0, 1'b0);
        cooldown_spawn(10'd0, 10'd0, 1'b0);

        // Enemy dies in cooldown: never fires.
        e_y = 10'd100;
        repeat (30) tick_none();
        @(negedge clk);
        enemy_en = 1'b0;
        repeat (100) tick_none();

        // Enemy dies in flight: bullet completes, then silence.
        @(negedge clk);
        enemy_en = 1'b1;
        cooldown_spawn(10'd639, 10'd140, 1'b1);
        repeat (5) tick_move();
        @(negedge clk);
        enemy_en = 1'b0;
        fly_out();
        repeat (100) tick_none();

        // Asynchronous reset mid-flight.
        @(negedge clk);
        enemy_en = 1'b1;
        cooldown_spawn(10'd639, 10'd140, 1'b1);
        repeat (3) tick_move();
        @(posedge clk);
        #2;
        es = '0;
        push("async_reset");
        rst = 1'b1;
        #1 check_now("async_reset_now", zero);
        @(negedge clk);
        rst = 1'b0;

        // 256 off-screen spawns wrap the shot counter back to zero.
        e_y = 10'd450;
        for (int i = 0; i < 256; i++) cooldown_spawn(10'd0, 10'd0, 1'b0);
        repeat (4) @(negedge clk);
        check_now("shots_wrap", zero);

        repeat (2) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d unmatched expectations (next %s), required 0",
                     expq.size(), nameq[0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
